// File: rtl/mem_pkg.sv
// Shared types and constants for the wait-stated memory responder.
package mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic [15:0] MMIO_ADDR           = 16'hFFFF;
  localparam int          DEFAULT_DEPTH       = 256;
  localparam int          DEFAULT_WAIT_STATES = 2;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between a requester and mem_responder.
interface mem_responder_if;
  logic [15:0] mar;
  logic [15:0] mdr;
  logic        rd_req;
  logic        wr_req;
  logic [15:0] rdata;
  logic        ready;
  logic        busy;
  logic        err;

  modport master (output mar, mdr, rd_req, wr_req,
                  input  rdata, ready, busy, err);
  modport slave  (input  mar, mdr, rd_req, wr_req,
                  output rdata, ready, busy, err);
endinterface

// File: rtl/sram_array.sv
// 16-bit word storage: one write port, one synchronous read port with a held output register.
module sram_array #(
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);

  logic [15:0] mem [DEPTH];
  logic [15:0] rdata_q, rdata_d;

  // The array itself is deliberately never reset; only the read register is.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  always_ff @(posedge clk) begin
    if (reset) rdata_q <= 16'h0000;
    else       rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Single-access memory responder with programmable wait states; define MMIO_EN to map
// address 16'hFFFF onto the sw input (reads) and hex display register (writes).
//   state  | meaning
//   S_IDLE | waiting for a single rd_req or wr_req
//   S_WAIT | counting down wait states
//   S_RESP | ready pulse; write committed / read data loaded on entry
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int WAIT_STATES = DEFAULT_WAIT_STATES
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus
`ifdef MMIO_EN
  ,
  input  logic [15:0]     sw,
  output logic [15:0]     hex
`endif
);

  localparam int         AW = $clog2(DEPTH);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   data_q, data_d;
  logic          wr_op_q, wr_op_d;
  logic          mmio_q, mmio_d;
  logic          err_q, err_d;
  logic          enter_resp;
  logic          mar_is_mmio;
  logic          mem_we, mem_re;
  logic [15:0]   mem_rdata;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    wr_op_d    = wr_op_q;
    mmio_d     = mmio_q;
    err_d      = 1'b0;
    enter_resp = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.rd_req && bus.wr_req) begin
          err_d = 1'b1;
        end else if (bus.rd_req || bus.wr_req) begin
          addr_d  = bus.mar[AW-1:0];
          data_d  = bus.mdr;
          wr_op_d = bus.wr_req;
          mmio_d  = mar_is_mmio;
          cnt_d   = WS;
          if (WAIT_STATES == 0) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      data_q  <= 16'h0000;
      wr_op_q <= 1'b0;
      mmio_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_op_q <= wr_op_d;
      mmio_q  <= mmio_d;
      err_q   <= err_d;
    end
  end

  // The *_d values carry the access in both the zero-wait and counted paths.
  assign mem_we = enter_resp &&  wr_op_d && !mmio_d && !reset;
  assign mem_re = enter_resp && !wr_op_d && !mmio_d && !reset;

  sram_array #(.DEPTH(DEPTH)) u_sram (
    .clk   (clk),
    .reset (reset),
    .we    (mem_we),
    .waddr (addr_d),
    .wdata (data_d),
    .re    (mem_re),
    .raddr (addr_d),
    .rdata (mem_rdata)
  );

`ifdef MMIO_EN
  logic [15:0] sw_q, sw_d;
  logic [15:0] hex_q, hex_d;
  logic        rd_mmio_q, rd_mmio_d;

  assign mar_is_mmio = (bus.mar == MMIO_ADDR);

  always_comb begin
    sw_d      = sw_q;
    hex_d     = hex_q;
    rd_mmio_d = rd_mmio_q;
    if (enter_resp) begin
      if (wr_op_d) begin
        if (mmio_d) hex_d = data_d;
      end else begin
        rd_mmio_d = mmio_d;
        if (mmio_d) sw_d = sw;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_q      <= 16'h0000;
      hex_q     <= 16'h0000;
      rd_mmio_q <= 1'b0;
    end else begin
      sw_q      <= sw_d;
      hex_q     <= hex_d;
      rd_mmio_q <= rd_mmio_d;
    end
  end

  assign hex       = hex_q;
  assign bus.rdata = rd_mmio_q ? sw_q : mem_rdata;
`else
  assign mar_is_mmio = 1'b0;
  assign bus.rdata   = mem_rdata;
`endif

  assign bus.ready = (state_q == S_RESP);
  assign bus.busy  = (state_q != S_IDLE);
  assign bus.err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (DEPTH=256, WAIT_STATES=2); MMIO_EN selects the I/O checks.
module tb_mem_responder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_responder_if bus();

`ifdef MMIO_EN
  logic [15:0] sw;
  logic [15:0] hex;
`endif

  mem_responder #(.DEPTH(256), .WAIT_STATES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef MMIO_EN
    ,
    .sw    (sw),
    .hex   (hex)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  int lat;
  int pulses;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a one-cycle request, then count negedges until ready (-1 on timeout).
  task automatic access(input logic r, input logic w, input logic [15:0] a,
                        input logic [15:0] d, output int l);
    @(negedge clk);
    bus.rd_req = r; bus.wr_req = w; bus.mar = a; bus.mdr = d;
    @(negedge clk);
    bus.rd_req = 1'b0; bus.wr_req = 1'b0;
    l = 1;
    while (!bus.ready && l < 20) begin
      @(negedge clk);
      l++;
    end
    if (!bus.ready) l = -1;
  endtask

  initial begin
    bus.mar = 16'h0; bus.mdr = 16'h0; bus.rd_req = 1'b0; bus.wr_req = 1'b0;
    reset = 1'b1;
`ifdef MMIO_EN
    sw = 16'h00C3;
`endif
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.ready), 32'h0);
    check("rst_busy",  32'(bus.busy),  32'h0);
    check("rst_err",   32'(bus.err),   32'h0);
    check("rst_rdata", 32'(bus.rdata), 32'h0);
`ifdef MMIO_EN
    check("rst_hex",   32'(hex),       32'h0);
`endif
    reset = 1'b0;

    // write then read back, 3-cycle latency each
    access(1'b0, 1'b1, 16'h0010, 16'hBEEF, lat);
    check("wr_lat",       32'(lat),      32'd3);
    check("busy_in_resp", 32'(bus.busy), 32'h1);
    @(negedge clk);
    check("ready_1cyc",   32'(bus.ready), 32'h0);
    check("busy_idle",    32'(bus.busy),  32'h0);
    access(1'b1, 1'b0, 16'h0010, 16'h0000, lat);
    check("rd_lat",   32'(lat),       32'd3);
    check("rd_beef",  32'(bus.rdata), 32'hBEEF);

    // address wrap at DEPTH=256
    access(1'b0, 1'b1, 16'h0105, 16'h1234, lat);
    access(1'b1, 1'b0, 16'h0005, 16'h0000, lat);
    check("wrap_lat",  32'(lat),       32'd3);
    check("wrap_data", 32'(bus.rdata), 32'h1234);
    repeat (3) @(negedge clk);
    check("rdata_held", 32'(bus.rdata), 32'h1234);

    // simultaneous rd/wr in IDLE
    access(1'b0, 1'b1, 16'h0030, 16'h5555, lat);
    @(negedge clk);
    bus.rd_req = 1'b1; bus.wr_req = 1'b1; bus.mar = 16'h0030; bus.mdr = 16'h9999;
    @(negedge clk);
    bus.rd_req = 1'b0; bus.wr_req = 1'b0;
    check("err_pulse",   32'(bus.err),   32'h1);
    check("err_noready", 32'(bus.ready), 32'h0);
    check("err_nobusy",  32'(bus.busy),  32'h0);
    @(negedge clk);
    check("err_1cyc",    32'(bus.err),   32'h0);
    check("err_noready2", 32'(bus.ready), 32'h0);
    access(1'b1, 1'b0, 16'h0030, 16'h0000, lat);
    check("err_nowrite", 32'(bus.rdata), 32'h5555);

    // request during WAIT is ignored
    @(negedge clk);
    bus.rd_req = 1'b1; bus.mar = 16'h0010;
    @(negedge clk);
    bus.mar = 16'h0005;
    @(negedge clk);
    bus.rd_req = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.ready) pulses++;
      @(negedge clk);
    end
    check("wait_ign_pulses", 32'(pulses),    32'd1);
    check("wait_ign_data",   32'(bus.rdata), 32'hBEEF);

    // reset in WAIT aborts a write
    access(1'b0, 1'b1, 16'h0020, 16'h1111, lat);
    @(negedge clk);
    bus.wr_req = 1'b1; bus.mar = 16'h0020; bus.mdr = 16'hAAAA;
    @(negedge clk);
    bus.wr_req = 1'b0;
    check("abort_busy_pre", 32'(bus.busy), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy",  32'(bus.busy),  32'h0);
    check("abort_ready", 32'(bus.ready), 32'h0);
    check("abort_rdata", 32'(bus.rdata), 32'h0);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.ready) pulses++;
      @(negedge clk);
    end
    check("abort_nopulse", 32'(pulses), 32'd0);
    access(1'b1, 1'b0, 16'h0020, 16'h0000, lat);
    check("abort_old", 32'(bus.rdata), 32'h1111);
    access(1'b1, 1'b0, 16'h0010, 16'h0000, lat);
    check("store_kept", 32'(bus.rdata), 32'hBEEF);

    // back-to-back accesses at the minimum period
    access(1'b0, 1'b1, 16'h0040, 16'h0A0A, lat);
    check("b2b_lat1", 32'(lat), 32'd3);
    access(1'b1, 1'b0, 16'h0040, 16'h0000, lat);
    check("b2b_lat2", 32'(lat),       32'd3);
    check("b2b_data", 32'(bus.rdata), 32'h0A0A);

`ifdef MMIO_EN
    access(1'b0, 1'b1, 16'h00FF, 16'h3C3C, lat);
    access(1'b1, 1'b0, 16'hFFFF, 16'h0000, lat);
    check("mmio_rd_lat", 32'(lat),       32'd3);
    check("mmio_rd_sw",  32'(bus.rdata), 32'h00C3);
    access(1'b0, 1'b1, 16'hFFFF, 16'h0042, lat);
    check("mmio_wr_lat", 32'(lat), 32'd3);
    @(negedge clk);
    check("mmio_hex",    32'(hex), 32'h0042);
    access(1'b1, 1'b0, 16'h00FF, 16'h0000, lat);
    check("mmio_store_untouched", 32'(bus.rdata), 32'h3C3C);
`else
    access(1'b0, 1'b1, 16'hFFFF, 16'h7777, lat);
    access(1'b1, 1'b0, 16'h00FF, 16'h0000, lat);
    check("ffff_plain", 32'(bus.rdata), 32'h7777);
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH, default 256: number of 16-bit storage words; power of two, 2..65536.
REQ-002 Parameter WAIT_STATES, default 2: wait cycles inserted before each access completes; range 0..15.
REQ-003 Port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  reset, synchronous, active-high.
REQ-005 Port mar  input  16  word address of the access.
REQ-006 Port mdr  input  16  write data.
REQ-007 Port rd_req  input  1  read request, one-cycle pulse per access.
REQ-008 Port wr_req  input  1  write request, one-cycle pulse per access.
REQ-009 Port rdata  output  16  read data, valid when ready=1 for a read, held until the next read completes.
REQ-010 Port ready  output  1  one-cycle completion pulse for each accepted access.
REQ-011 Port busy  output  1  high while an access is in flight (states WAIT and RESP).
REQ-012 Port err  output  1  one-cycle pulse when rd_req and wr_req are both sampled high in IDLE.
REQ-013 Ports sw (input 16, switch value) and hex (output 16, display register) SHALL exist only when MMIO_EN is defined.

Function
REQ-014 FSM states: IDLE, WAIT, RESP.
REQ-015 IDLE: exactly one of rd_req/wr_req high -> latch mar, mdr and op; load the wait counter with WAIT_STATES; go to WAIT, or to RESP if WAIT_STATES=0.
REQ-016 WAIT: decrement the counter each cycle; on the cycle it reads 1, go to RESP.
REQ-017 Latency: request accepted at edge N -> ready=1 during cycle N+1+WAIT_STATES.
REQ-018 Write commits to storage on the edge entering RESP; read data loads rdata on the same edge.
REQ-019 RESP: ready=1 for exactly one cycle, then unconditionally to IDLE.
REQ-020 Requests sampled in WAIT or RESP SHALL be ignored (not queued).
REQ-021 rd_req and wr_req both high in IDLE: no access, stay IDLE, err=1 next cycle, ready stays 0.
REQ-022 Address index = mar mod DEPTH (low log2(DEPTH) bits); upper bits are ignored, giving wrap-around.
REQ-023 Back-to-back: a new request is accepted on the first IDLE cycle after RESP, giving a minimum access period of WAIT_STATES+2 cycles.

Reset
REQ-024 reset=1: state IDLE, counter 0, ready 0, busy 0, err 0, rdata 16'h0000, hex 16'h0000.
REQ-025 Reset mid-access SHALL abort the access: no write commit, no ready pulse.
REQ-026 Storage contents SHALL NOT be cleared by reset.

Configuration
REQ-027 Macro MMIO_EN defined: address 16'hFFFF is memory-mapped I/O. Reads return sw as sampled on the edge entering RESP. Writes load hex. Storage is not touched. Latency is unchanged.
REQ-028 Macro MMIO_EN undefined: 16'hFFFF is an ordinary storage address (wraps per REQ-022); no sw or hex ports.

Structure
REQ-029 Package mem_pkg SHALL hold the state enum, the MMIO_ADDR constant (16'hFFFF) and the default DEPTH and WAIT_STATES values.
REQ-030 Storage SHALL be a sub-module sram_array with one write port and one synchronous read port, sized by DEPTH.

Verification
REQ-031 WAIT_STATES=2: write mar=0x0010 mdr=0xBEEF, then read 0x0010 -> ready 3 cycles after each request; rdata=0xBEEF.
REQ-032 DEPTH=256: write 0x0105 data 0x1234, then read 0x0005 -> rdata=0x1234 (wrap).
REQ-033 rd_req=wr_req=1 in IDLE -> err pulse next cycle, no ready, and a read of that address returns its previous contents.
REQ-034 rd_req pulsed during WAIT -> ignored; exactly one ready pulse results.
REQ-035 reset asserted in WAIT during a write of 0xAAAA to 0x0020 -> busy=0 next cycle, no ready, and a later read of 0x0020 returns the old value.
REQ-036 MMIO_EN defined, sw=0x00C3: read 0xFFFF -> rdata=0x00C3; write 0xFFFF data 0x0042 -> hex=0x0042 and storage word 0xFF is unchanged.
